// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage, instruction memory and the decode/execute side.
// "master" is the fetch unit; "slave" is the environment (memory + datapath).
interface fetch_unit_if #(
    parameter int CNT_W = 32
);
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic             imem_ready;
    logic             instr_valid;
    logic [31:0]      Instr;
    logic [5:0]       Opcode;
    logic [5:0]       Funct;
    logic [31:0]      PC;
    logic [31:0]      PCPlus4;
    logic             exec_done;
    logic             PCSrc;
    logic             Jump;
    logic [31:0]      SignImm;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output imem_req, imem_addr, instr_valid, Instr, Opcode, Funct,
               PC, PCPlus4, retired_count,
        input  imem_rdata, imem_ready, exec_done, PCSrc, Jump, SignImm
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, Instr, Opcode, Funct,
               PC, PCPlus4, retired_count,
        output imem_rdata, imem_ready, exec_done, PCSrc, Jump, SignImm
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ready, holds the
// instruction for decode and picks the next PC from the branch/jump controls.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master fu
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [CNT_W-1:0] r_count;

    logic             w_latch;
    logic             w_retire;
    logic             w_req;
    logic             w_valid;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_branch_off;
    logic [31:0]      w_next_pc;

    assign w_pc_plus4   = r_pc + 32'd4;
    // Shifting in 32 bits drops SignImm[31:30], matching the wrap-around rule.
    assign w_branch_off = fu.SignImm << 2;

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (fu.Jump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (fu.PCSrc) begin
            w_next_pc = w_pc_plus4 + w_branch_off;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_retire     = 1'b0;
        w_req        = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = REQ;
            end
            REQ: begin
                w_req = 1'b1;
                if (fu.imem_ready) begin
                    w_latch      = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                w_valid = 1'b1;
                if (fu.exec_done) begin
                    w_retire     = 1'b1;
                    w_state_next = REQ;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_instr <= fu.imem_rdata;
            end
            if (w_retire) begin
                r_pc    <= w_next_pc;
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign fu.imem_req      = w_req;
    assign fu.imem_addr     = r_pc;
    assign fu.instr_valid   = w_valid;
    assign fu.Instr         = r_instr;
    assign fu.Opcode        = r_instr[31:26];
    assign fu.Funct         = r_instr[5:0];
    assign fu.PC            = r_pc;
    assign fu.PCPlus4       = w_pc_plus4;
    assign fu.retired_count = r_count;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector chain, reset corner cases,
// then randomized fetch/execute traffic against a behavioural PC model.
module tb_fetch_unit;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.CNT_W(CNT_W)) ifc ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fu  (ifc.master)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        pcsrc;
        logic        jump;
        logic [31:0] simm;
        int          wait_n;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vt[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req"},   32'(ifc.imem_req), 32'd0);
        chk({tag, "_valid"}, 32'(ifc.instr_valid), 32'd0);
        chk({tag, "_pc"},    ifc.PC, 32'd0);
        chk({tag, "_instr"}, ifc.Instr, 32'd0);
        chk({tag, "_cnt"},   32'(ifc.retired_count), 32'd0);
    endtask

    // Behavioural next-PC rule, computed with plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr,
                                               input logic pcsrc, input logic jump,
                                               input logic [31:0] simm);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (jump) return (p4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 32'd4);
        if (pcsrc) return p4 + simm * 32'd4;
        return p4;
    endfunction

    initial begin
        logic [31:0] cur;
        logic [31:0] m_pc;
        logic [31:0] m_instr;
        logic [31:0] m_cnt;
        logic        pj;
        logic        ps;
        logic [31:0] si;

        vt[0]  = '{32'h8C01_0004, 1'b1, 1'b0, 32'h0000_003F, 0, 32'h0000_0100};
        vt[1]  = '{32'h0022_1820, 1'b0, 1'b0, 32'h1234_0000, 5, 32'h0000_0104};
        vt[2]  = '{32'h1000_ABCD, 1'b1, 1'b0, 32'hFFFF_FFFE, 1, 32'h0000_0100};
        vt[3]  = '{32'hAC01_0010, 1'b1, 1'b0, 32'hFFFF_FFFE, 0, 32'h0000_00FC};
        vt[4]  = '{32'h1234_5678, 1'b1, 1'b0, 32'h0000_0003, 2, 32'h0000_010C};
        vt[5]  = '{32'h2000_0000, 1'b1, 1'b0, 32'h0FFF_FFC0, 0, 32'h4000_0010};
        vt[6]  = '{32'h0800_0040, 1'b1, 1'b1, 32'h0000_0055, 0, 32'h4000_0100};
        vt[7]  = '{32'hFFFF_FFFF, 1'b1, 1'b0, 32'h2FFF_FFBE, 3, 32'hFFFF_FFFC};
        vt[8]  = '{32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 0, 32'h0000_0000};
        vt[9]  = '{32'h0BFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 1, 32'h0FFF_FFFC};
        vt[10] = '{32'h1000_0001, 1'b1, 1'b0, 32'hC000_0001, 0, 32'h1000_0004};

        ifc.imem_rdata = 32'd0;
        ifc.imem_ready = 1'b0;
        ifc.exec_done  = 1'b0;
        ifc.PCSrc      = 1'b0;
        ifc.Jump       = 1'b0;
        ifc.SignImm    = 32'd0;

        // Reset with noisy inputs: reset must win.
        rst = 1'b1;
        ifc.imem_ready = 1'b1;
        ifc.exec_done  = 1'b1;
        tick();
        tick();
        chk_reset_state("reset");
        ifc.exec_done  = 1'b0;

        // First non-reset edge leaves IDLE; ready there is ignored.
        rst = 1'b0;
        ifc.imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("rel_req",   32'(ifc.imem_req), 32'd1);
        chk("rel_addr",  ifc.imem_addr, 32'd0);
        chk("rel_valid", 32'(ifc.instr_valid), 32'd0);
        chk("rel_instr", ifc.Instr, 32'd0);
        $display("reset release: req=%0d addr=%h", ifc.imem_req, ifc.imem_addr);

        cur = 32'd0;
        for (int i = 0; i < 11; i++) begin
            chk("vec_req",  32'(ifc.imem_req), 32'd1);
            chk("vec_addr", ifc.imem_addr, cur);
            for (int w = 0; w < vt[i].wait_n; w++) begin
                ifc.imem_ready = 1'b0;
                ifc.imem_rdata = $urandom;
                tick();
                chk("wait_req",   32'(ifc.imem_req), 32'd1);
                chk("wait_addr",  ifc.imem_addr, cur);
                chk("wait_valid", 32'(ifc.instr_valid), 32'd0);
            end
            ifc.imem_ready = 1'b1;
            ifc.imem_rdata = vt[i].rdata;
            tick();
            ifc.imem_ready = 1'b0;
            ifc.imem_rdata = $urandom;
            chk("hold_valid",  32'(ifc.instr_valid), 32'd1);
            chk("hold_req",    32'(ifc.imem_req), 32'd0);
            chk("hold_instr",  ifc.Instr, vt[i].rdata);
            chk("hold_opcode", 32'(ifc.Opcode), vt[i].rdata >> 26);
            chk("hold_funct",  32'(ifc.Funct), vt[i].rdata & 32'h3F);
            chk("hold_pc",     ifc.PC, cur);
            chk("hold_pc4",    ifc.PCPlus4, cur + 32'd4);
            ifc.exec_done = 1'b1;
            ifc.PCSrc     = vt[i].pcsrc;
            ifc.Jump      = vt[i].jump;
            ifc.SignImm   = vt[i].simm;
            tick();
            ifc.exec_done = 1'b0;
            chk("next_pc",    ifc.PC, vt[i].exp_next);
            chk("next_addr",  ifc.imem_addr, vt[i].exp_next);
            chk("next_req",   32'(ifc.imem_req), 32'd1);
            chk("next_valid", 32'(ifc.instr_valid), 32'd0);
            chk("next_cnt",   32'(ifc.retired_count), 32'(i + 1));
            $display("vec %0d: pc=%h instr=%h pcsrc=%0d jump=%0d -> next=%h cnt=%0d",
                     i, cur, vt[i].rdata, vt[i].pcsrc, vt[i].jump, ifc.PC, ifc.retired_count);
            cur = vt[i].exp_next;
        end

        // Reset while a request is being completed; the late ready is ignored.
        ifc.imem_ready = 1'b1;
        ifc.imem_rdata = 32'hCAFE_F00D;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("rst_req");
        tick();
        chk("rst_req_late_valid", 32'(ifc.instr_valid), 32'd0);
        chk("rst_req_late_req",   32'(ifc.imem_req), 32'd1);
        chk("rst_req_late_instr", ifc.Instr, 32'd0);
        $display("reset in REQ: pc=%h req=%0d valid=%0d", ifc.PC, ifc.imem_req, ifc.instr_valid);

        // Reset during HOLD with exec_done: instruction is dropped, not counted.
        tick();
        ifc.imem_ready = 1'b0;
        chk("pre_rst_hold_valid", 32'(ifc.instr_valid), 32'd1);
        ifc.exec_done = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifc.exec_done = 1'b0;
        chk_reset_state("rst_hold");
        tick();
        $display("reset in HOLD: pc=%h cnt=%0d", ifc.PC, ifc.retired_count);

        // Randomized traffic against the behavioural model.
        m_pc  = 32'd0;
        m_cnt = 32'd0;
        for (int n = 0; n < 40; n++) begin
            chk("rnd_req",  32'(ifc.imem_req), 32'd1);
            chk("rnd_addr", ifc.imem_addr, m_pc);
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                ifc.imem_ready = 1'b0;
                ifc.exec_done  = 1'($urandom);
                ifc.imem_rdata = $urandom;
                tick();
                chk("rnd_wait_valid", 32'(ifc.instr_valid), 32'd0);
                chk("rnd_wait_addr",  ifc.imem_addr, m_pc);
            end
            m_instr = $urandom;
            ifc.imem_rdata = m_instr;
            ifc.imem_ready = 1'b1;
            ifc.exec_done  = 1'($urandom);
            tick();
            ifc.exec_done = 1'b0;
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
                ifc.imem_ready = 1'($urandom);
                ifc.imem_rdata = $urandom;
                tick();
                chk("rnd_hold_stable", ifc.Instr, m_instr);
            end
            chk("rnd_valid", 32'(ifc.instr_valid), 32'd1);
            chk("rnd_instr", ifc.Instr, m_instr);
            chk("rnd_pc",    ifc.PC, m_pc);
            pj = ($urandom_range(0, 3) == 0);
            ps = 1'($urandom);
            si = $urandom;
            ifc.Jump      = pj;
            ifc.PCSrc     = ps;
            ifc.SignImm   = si;
            ifc.exec_done = 1'b1;
            tick();
            ifc.exec_done  = 1'b0;
            ifc.imem_ready = 1'b0;
            m_pc  = model_next(m_pc, m_instr, ps, pj, si);
            m_cnt = (m_cnt + 32'd1) % (32'd1 << CNT_W);
            chk("rnd_next_pc", ifc.PC, m_pc);
            chk("rnd_cnt",     32'(ifc.retired_count), m_cnt);
            $display("rnd %0d: instr=%h pcsrc=%0d jump=%0d simm=%h -> pc=%h cnt=%0d",
                     n, m_instr, ps, pj, si, ifc.PC, ifc.retired_count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the core control unit. It owns the program counter and fetches from a variable-latency instruction memory over a req/ready handshake. It presents the held instruction and its Opcode/Funct fields to the decoder. When execution completes, it consumes the decoder's PCSrc/Jump outputs to select the next PC. It also keeps a retired-instruction counter for bring-up and debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; equals PC.
imem_rdata  input  32  instruction word; valid when imem_ready=1.
imem_ready  input  1  memory completes the current request this cycle.
instr_valid  output  1  Instr/Opcode/Funct hold a valid instruction.
Instr  output  32  held instruction word.
Opcode  output  6  Instr[31:26].
Funct  output  6  Instr[5:0].
PC  output  32  address of the held instruction.
PCPlus4  output  32  PC + 4, modulo 2^32.
exec_done  input  1  datapath has finished the held instruction; PCSrc/Jump/SignImm are valid.
PCSrc  input  1  take the branch (from the control unit).
Jump  input  1  take the jump (from the control unit).
SignImm  input  32  sign-extended branch immediate.
retired_count  output  CNT_W  number of instructions accepted via exec_done.

Behaviour:
- Reset values: PC=RESET_PC, Instr=0, imem_req=0, instr_valid=0, retired_count=0, state=IDLE. Reset wins over every other input in the same cycle.
- FSM (registered state; imem_req and instr_valid decode from state only, Moore):
  - IDLE: imem_req=0, instr_valid=0. Always goes to REQ on the next edge.
  - REQ: imem_req=1, imem_addr=PC. If imem_ready=1, latch Instr<=imem_rdata and go to HOLD. Otherwise stay in REQ.
  - HOLD: imem_req=0, instr_valid=1. If exec_done=1, load PC<=next_pc, increment retired_count, and go to REQ. Otherwise stay in HOLD with Instr, PC and outputs stable.
- next_pc priority:
  - Jump=1: {PCPlus4[31:28], Instr[25:0], 2'b00}.
  - Else PCSrc=1: PCPlus4 + (SignImm << 2).
  - Else: PCPlus4.
- Arithmetic: 32-bit, wraps modulo 2^32 with no error. SignImm<<2 discards the top 2 bits. PC[1:0] stays 00 whenever RESET_PC is aligned.
- Latency:
  - After rst deasserts: IDLE for 1 cycle, then REQ.
  - With imem_ready=1 in the first REQ cycle, instr_valid rises 2 cycles after the first non-reset edge.
  - Minimum issue interval: 2 cycles per instruction (REQ→HOLD→REQ).
- Ignored inputs:
  - exec_done outside HOLD has no effect.
  - imem_ready outside REQ has no effect; imem_rdata is not sampled.
  - PCSrc/Jump/SignImm are sampled only on an exec_done edge in HOLD.
- Jump and PCSrc both 1: Jump wins.
- retired_count wraps from all-ones to 0 silently.
- Reset mid-request (REQ with imem_ready pending): the request is abandoned; imem_req=0 after the reset edge; a late imem_ready is ignored.
- Reset during HOLD: the held instruction is discarded and not counted.
- Opcode, Funct and PCPlus4 are combinational from Instr/PC. They hold their value when instr_valid=0 but carry no meaning then.

Test Plan:
- Reset release, imem_ready tied 1, RESET_PC=0: imem_addr=0 in cycle 1; instr_valid=1 in cycle 2; Opcode=imem_rdata[31:26].
- Sequential: PC=0x100, exec_done with PCSrc=0, Jump=0 → next imem_addr=0x104; retired_count increments by 1.
- Branch: PC=0x100, PCSrc=1, SignImm=0xFFFF_FFFE → next PC=0x0FC. Then SignImm=3 from PC=0x0FC → next PC=0x10C.
- Jump priority: PC=0x4000_0010, Instr[25:0]=0x000_0040, Jump=1 and PCSrc=1 → next PC=0x4000_0100.
- Memory wait: imem_ready held 0 for 5 cycles → imem_req stays 1 and imem_addr stays stable; instr_valid=0 throughout. Instr latches on the ready cycle.
- Reset mid-operation: assert rst in REQ with imem_ready=1 in the same cycle → PC=RESET_PC, instr_valid=0, retired_count=0, Instr=0 next cycle. Wrap check: PC=0xFFFF_FFFC sequential → next PC=0.
